// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
// Module   : period_meter
// Purpose  : Recovers the period, in clk cycles, of a periodic pulse or
//            square wave on sig_in. Each rising edge of the synchronized
//            input closes one period and opens the next. Results go out on
//            a valid/ready interface; a result that cannot be delivered is
//            dropped and flagged on overrun. Silence longer than TIMEOUT
//            cycles abandons the measurement and pulses timeout.
// Ports    : clk, rst_n (async, active-low)
//            enable       - level-sensitive measurement enable
//            sig_in       - measured signal, may be asynchronous to clk
//            meas_ready   - downstream accepts meas_period
//            meas_period  - measured period [CNT_W]
//            meas_valid   - result held until accepted
//            timeout      - 1-cycle pulse, TIMEOUT cycles without an edge
//            overrun      - 1-cycle pulse, completed result dropped
// Option   : PERIOD_MINMAX_EN adds stats_clr, min_period, max_period.
// Revision : 1.0 - initial release
// ============================================================================
module period_meter #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_valid,
  output logic             timeout,
  output logic             overrun
`ifdef PERIOD_MINMAX_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] min_period,
  output logic [CNT_W-1:0] max_period
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   rise;
  logic                   result_done;

  // Synchronizer plus one extra stage for edge detection; runs regardless
  // of enable so the first edge after enabling is clean.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
  assign prev_d = sync_q[SYNC_STAGES-1];
  assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_done = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ARM;
      end
      ARM: begin
        cnt_d = '0;
        if (!enable) begin
          state_d = IDLE;
        end else if (rise) begin
          state_d = MEASURE;
          cnt_d   = ONE_C;
        end
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise) begin
          // An edge wins over a simultaneous TIMEOUT count; the reload to 1
          // lets back-to-back periods run with no dead cycle.
          result_done = 1'b1;
          cnt_d       = ONE_C;
        end else if (cnt_q == TIMEOUT_C) begin
          timeout = 1'b1;
          cnt_d   = '0;
          state_d = ARM;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output holding register: a pending result is never overwritten unless
  // it is being accepted in the same cycle.
  always_comb begin
    valid_d  = valid_q;
    period_d = period_q;
    overrun  = 1'b0;
    if (result_done) begin
      if (!valid_q || meas_ready) begin
        valid_d  = 1'b1;
        period_d = cnt_q;
      end else begin
        overrun = 1'b1;
      end
    end else if (valid_q && meas_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      period_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      period_q <= period_d;
      valid_q  <= valid_d;
    end
  end

  assign meas_period = period_q;
  assign meas_valid  = valid_q;

`ifdef PERIOD_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [CNT_W-1:0] min_base;
  logic [CNT_W-1:0] max_base;

  // Clear first, then fold in a coinciding result. Dropped results count.
  always_comb begin
    min_base = stats_clr ? '1 : min_q;
    max_base = stats_clr ? '0 : max_q;
    min_d    = min_base;
    max_d    = max_base;
    if (result_done) begin
      if (cnt_q < min_base) min_d = cnt_q;
      if (cnt_q > max_base) max_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_period = min_q;
  assign max_period = max_q;
`endif

endmodule
`default_nettype wire

// File: doc/period_meter.md
Name: period_meter

Overview:
Measures the period, in clk cycles, of a periodic pulse or square wave on sig_in. Typical sources are tick outputs of the clock-divider blocks or external inputs. Acts as the receive-side counterpart to the divider: the divider generates a tick every N cycles, this block recovers N. Results are delivered on a valid/ready interface to downstream logic such as a display or the UART report path.

Parameters:
CNT_W, 32, width of the period counter and of meas_period.
TIMEOUT, 1000000, cycles without a rising edge before the measurement is abandoned; must satisfy 2 <= TIMEOUT < 2^CNT_W.
SYNC_STAGES, 2, flip-flop stages in the sig_in synchronizer; minimum 2.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset, asynchronous, active-low.
enable  input  1  measurement enable; level-sensitive.
sig_in  input  1  signal under measurement; may be asynchronous to clk.
meas_ready  input  1  downstream accepts meas_period when high with meas_valid.
meas_period  output  CNT_W  measured period in clk cycles; stable while meas_valid=1.
meas_valid  output  1  result available; held until accepted.
timeout  output  1  one-cycle pulse when TIMEOUT elapses with no edge.
overrun  output  1  one-cycle pulse when a completed measurement is dropped.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, synchronizer flops 0.
- Synchronizer: SYNC_STAGES flops, then one extra flop (prev). rise = sync & ~prev. The rise-detect cycle falls SYNC_STAGES+1 clocks after sig_in goes high. The synchronizer runs regardless of enable.
- Period definition: rise-detect at cycles t0 and t1 (consecutive) gives period = t1 - t0. Minimum measurable period is 2.
- State machine:
  - IDLE: counter held at 0. Go to ARM when enable=1.
  - ARM: waiting for the first rise. On rise, go to MEASURE with the counter at 1 on the next cycle.
  - MEASURE: counter increments every cycle.
    - On rise: result = current count, counter reloads to 1, stay in MEASURE (back-to-back periods, no dead cycle).
    - If count reaches TIMEOUT with no rise: pulse timeout for 1 cycle, clear the counter, go to ARM; no result is produced.
  - enable=0 in any state: go to IDLE next cycle and clear the counter. Any partial measurement is discarded. A pending meas_valid/meas_period is kept until accepted.
- Output handshake:
  - A result completes on the rise cycle. meas_valid and meas_period update on the following clock edge (1-cycle latency).
  - meas_valid falls on the cycle after meas_valid & meas_ready, unless a new result loads in the same edge.
  - New result while meas_valid=1 and meas_ready=0: the new result is dropped, the old one is kept, and overrun pulses for 1 cycle.
  - New result in the same cycle as meas_valid & meas_ready: the new result loads, meas_valid stays 1, no overrun.
- The counter never wraps, because TIMEOUT < 2^CNT_W.
- A rise in the same cycle as count==TIMEOUT is treated as a rise: the result is TIMEOUT and no timeout pulse is generated.

Optional Feature:
PERIOD_MINMAX_EN
- Defined:
  - Adds input stats_clr (1) and outputs min_period (CNT_W) and max_period (CNT_W).
  - Every completed result updates the min/max registers, including results dropped by overrun.
  - Reset and stats_clr set min to all-ones and max to 0.
  - stats_clr together with a result: the clear applies, then the result is folded in, so min = max = result.
- Not defined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- sig_in 1-cycle high pulse every 12 clk, enable=1, meas_ready=1 -> first result 12, then 12 every 12 cycles, no timeout or overrun.
- Square wave with period 2 (alternating each clk) -> meas_period=2 continuously.
- TIMEOUT=100, a single pulse then silence -> timeout pulse exactly 100 cycles after the first rise-detect; meas_valid never asserted; the next pulse pair gives a correct period.
- Pulses every 10 clk, meas_ready=0 for 35 cycles -> first result 10 held; overrun pulses at each of the next 3 rises; after meas_ready=1, meas_valid drops and the next result is 10.
- enable dropped mid-period, re-raised, pulses every 20 clk -> no result for the interrupted period; the first result after re-arm is 20.
- With PERIOD_MINMAX_EN: periods 8, 15, 11 -> min 8, max 15. stats_clr coinciding with a period-9 result -> min=max=9.
